mem_copy_engine: RTL and testbench

- Initiator-side client for the team's 2-read/1-write register-file memory (async read, sync write).
- On a start command, walks a source region through a read port and writes the data to a destination region through the write port, one word per cycle.
- Also has a fill mode that writes a constant.
- Used in the mips32 benchmark to preload and clear data memory, and as a DMA-style stressor for the memory's read/write ports.

---
 rtl/mem_copy_engine.sv | 118 +++++++++++
 tb/tb_mem_copy_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Copy/fill engine for a 2-read/1-write register-file memory.
// Walks a source region through the async read port and writes one word per
// cycle into a destination region. Fill mode writes a latched constant instead.
// Copy direction is chosen so that overlapping, non-wrapping regions behave
// like memmove.
module mem_copy_engine #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned BYTE_SIZE = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_SIZE-1:0] src,
  input  logic [ADDR_SIZE-1:0] dst,
  input  logic [ADDR_SIZE:0]   len,
  input  logic [BYTE_SIZE-1:0] fill_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] raddr,
  input  logic [BYTE_SIZE-1:0] rdata,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [BYTE_SIZE-1:0] wdata
);

  typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] raddr_q, raddr_d;
  logic [ADDR_SIZE-1:0] waddr_q, waddr_d;
  logic [ADDR_SIZE:0]   remain_q, remain_d;
  logic                 mode_q, mode_d;
  logic                 back_q, back_d;
  logic [BYTE_SIZE-1:0] fill_q, fill_d;

  logic                 accept;
  logic                 backward;
  logic [ADDR_SIZE-1:0] last_off;
  logic [ADDR_SIZE-1:0] step;

  // Offset of the last word; len == 2**ADDR_SIZE yields all-ones, i.e. wraps correctly.
  assign last_off = ADDR_SIZE'(len - (ADDR_SIZE + 1)'(1));
  assign backward = !mode && (dst > src);
  assign accept   = start && (state_q != StCopy);
  // All-ones is -1 modulo 2**ADDR_SIZE.
  assign step     = back_q ? '1 : ADDR_SIZE'(1);

  // Next-state logic: sequence the active transfer, then let an accepted command override.
  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    back_d   = back_q;
    fill_d   = fill_q;

    unique case (state_q)
      StCopy: begin
        raddr_d  = raddr_q + step;
        waddr_d  = waddr_q + step;
        remain_d = remain_q - (ADDR_SIZE + 1)'(1);
        if (remain_q == (ADDR_SIZE + 1)'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = state_q;
    endcase

    if (accept) begin
      mode_d   = mode;
      fill_d   = fill_data;
      back_d   = backward;
      remain_d = len;
      if (len == '0) begin
        state_d = StDone;
      end else begin
        state_d = StCopy;
        raddr_d = backward ? src + last_off : src;
        waddr_d = backward ? dst + last_off : dst;
      end
    end
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      raddr_q  <= '0;
      waddr_q  <= '0;
      remain_q <= '0;
      mode_q   <= 1'b0;
      back_q   <= 1'b0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
      back_q   <= back_d;
      fill_q   <= fill_d;
    end
  end

  // Outputs: control decoded from state only; wdata is combinational only through rdata.
  always_comb begin
    busy  = (state_q == StCopy);
    wen   = (state_q == StCopy);
    done  = (state_q == StDone);
    raddr = raddr_q;
    waddr = waddr_q;
    wdata = mode_q ? fill_q : rdata;
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed plan cases plus random transfers,
// checked cycle by cycle against a word-level reference model of the memory.
module tb_mem_copy_engine;

  localparam int Depth = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [3:0] src;
  logic [3:0] dst;
  logic [4:0] len;
  logic [7:0] fill_data;
  logic       busy;
  logic       done;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic       wen;
  logic [3:0] waddr;
  logic [7:0] wdata;

  logic [7:0] mem     [Depth];
  logic [7:0] ref_mem [Depth];

  int n_cmp = 0;
  int n_err = 0;

  bit         cur_mode;
  int         cur_src;
  int         cur_dst;
  int         cur_len;
  logic [7:0] cur_fill;

  mem_copy_engine #(
    .ADDR_SIZE(4),
    .BYTE_SIZE(8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .fill_data(fill_data),
    .busy     (busy),
    .done     (done),
    .raddr    (raddr),
    .rdata    (rdata),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  always #5 clock = ~clock;

  // Register-file memory: async read, sync write.
  assign rdata = mem[raddr];
  always @(posedge clock) if (wen) mem[waddr] <= wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem_incr();
    for (int i = 0; i < Depth; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
  endtask

  task automatic set_mem_rand();
    for (int i = 0; i < Depth; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < Depth; i++) chk($sformatf("%s mem[%0d]", tag, i), mem[i], ref_mem[i]);
  endtask

  // Present a command and step past the accepting edge.
  task automatic start_cmd(input bit m, input int s, input int d, input int l,
                           input logic [7:0] f, input bit hold);
    mode      = m;
    src       = 4'(s);
    dst       = 4'(d);
    len       = 5'(l);
    fill_data = f;
    start     = 1'b1;
    cur_mode  = m;
    cur_src   = s;
    cur_dst   = d;
    cur_len   = l;
    cur_fill  = f;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Check every write cycle of the current transfer, then the done cycle.
  // Reference: memmove-style ordering - high-to-low when copying and dst > src.
  task automatic body(input string tag, input bit pulse_mid);
    bit         back;
    int         off;
    int         wa;
    int         ra;
    logic [7:0] ed;
    back = !cur_mode && (cur_dst > cur_src);
    for (int i = 0; i < cur_len; i++) begin
      off = back ? cur_len - 1 - i : i;
      wa  = (cur_dst + off) % Depth;
      ra  = (cur_src + off) % Depth;
      ed  = cur_mode ? cur_fill : ref_mem[ra];
      chk($sformatf("%s w%0d busy", tag, i), busy, 1);
      chk($sformatf("%s w%0d wen", tag, i), wen, 1);
      chk($sformatf("%s w%0d done", tag, i), done, 0);
      chk($sformatf("%s w%0d waddr", tag, i), waddr, wa);
      chk($sformatf("%s w%0d raddr", tag, i), raddr, ra);
      chk($sformatf("%s w%0d wdata", tag, i), wdata, ed);
      ref_mem[wa] = ed;
      if (pulse_mid && i == 1) begin
        start     = 1'b1;
        mode      = 1'($urandom);
        src       = 4'($urandom);
        dst       = 4'($urandom);
        len       = 5'($urandom_range(0, 16));
        fill_data = 8'($urandom);
      end
      if (pulse_mid && i == 2) start = 1'b0;
      @(posedge clock);
      #1;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " done busy"}, busy, 0);
    chk({tag, " done wen"}, wen, 0);
  endtask

  task automatic idle_check(input string tag);
    @(posedge clock);
    #1;
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle wen"}, wen, 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    src       = '0;
    dst       = '0;
    len       = '0;
    fill_data = '0;
    set_mem_rand();
    repeat (2) @(posedge clock);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset wen", wen, 0);
    chk("reset raddr", raddr, 0);
    chk("reset waddr", waddr, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fill three words at 4..6.
    set_mem_rand();
    start_cmd(1, 0, 4, 3, 8'hA5, 0);
    body("fill", 0);
    idle_check("fill");
    check_mem("fill");

    // Forward copy 0..3 -> 8..11.
    set_mem_incr();
    start_cmd(0, 0, 8, 4, 8'h00, 0);
    body("fwd", 0);
    idle_check("fwd");
    check_mem("fwd");

    // Overlapping, dst > src: must run backward.
    set_mem_incr();
    start_cmd(0, 2, 4, 5, 8'h00, 0);
    body("ovl_back", 0);
    idle_check("ovl_back");
    check_mem("ovl_back");
    chk("ovl_back mem4", mem[4], 2);
    chk("ovl_back mem8", mem[8], 6);

    // Overlapping, dst < src: forward.
    set_mem_incr();
    start_cmd(0, 4, 2, 5, 8'h00, 0);
    body("ovl_fwd", 0);
    idle_check("ovl_fwd");
    check_mem("ovl_fwd");
    chk("ovl_fwd mem2", mem[2], 4);
    chk("ovl_fwd mem6", mem[6], 8);

    // Zero length: straight to done.
    set_mem_rand();
    start_cmd(0, 3, 9, 0, 8'h00, 0);
    body("len0", 0);
    idle_check("len0");
    check_mem("len0");

    // Source wraps past the top of memory.
    set_mem_incr();
    start_cmd(0, 14, 0, 4, 8'h00, 0);
    body("wrap", 0);
    idle_check("wrap");
    check_mem("wrap");

    // Full-depth clear.
    set_mem_rand();
    start_cmd(1, 7, 5, 16, 8'h00, 0);
    body("clr16", 0);
    idle_check("clr16");
    check_mem("clr16");
    chk("clr16 waddr end", waddr, 5);

    // start pulsed mid-transfer is ignored.
    set_mem_rand();
    start_cmd(0, 1, 9, 6, 8'h00, 0);
    body("pulse", 1);
    idle_check("pulse");
    check_mem("pulse");

    // start held through DONE: second transfer with no idle gap.
    set_mem_rand();
    start_cmd(1, 0, 8, 3, 8'h3C, 1);
    body("hold1", 0);
    @(posedge clock);
    #1;
    start = 1'b0;
    body("hold2", 0);
    idle_check("hold2");
    check_mem("hold");

    // Reset during the second write: only one word lands, no done.
    set_mem_rand();
    start_cmd(1, 5, 10, 5, 8'h3C, 0);
    chk("rst w0 wen", wen, 1);
    chk("rst w0 waddr", waddr, 10);
    ref_mem[10] = 8'h3C;
    @(posedge clock);
    #1;
    chk("rst w1 wen", wen, 1);
    reset = 1'b1;
    #1;
    chk("rst async wen", wen, 0);
    chk("rst async busy", busy, 0);
    chk("rst async done", done, 0);
    chk("rst async waddr", waddr, 0);
    chk("rst async raddr", raddr, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst no done", done, 0);
    @(posedge clock);
    #1;
    chk("rst after done", done, 0);
    chk("rst after wen", wen, 0);
    check_mem("rst");
    start_cmd(1, 0, 0, 2, 8'h77, 0);
    body("rst_fresh", 0);
    idle_check("rst_fresh");
    check_mem("rst_fresh");

    // Random transfers against the reference model.
    for (int t = 0; t < 25; t++) begin
      if (t % 5 == 0) set_mem_rand();
      start_cmd(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 16)), 8'($urandom), 0);
      body($sformatf("rnd%0d", t), 0);
      idle_check($sformatf("rnd%0d", t));
      check_mem($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
